// File: rtl/stride_top.sv
// Stride value predictor: per-entry last/stride/confidence tables, multi-lane lookup and merged feedback.
// Define VP_STRIDE_EN to build the stride table; otherwise it behaves as a last-value predictor.
module stride_top #(
   parameter int P_STORAGE_SIZE = 2048,
   parameter int P_CONF_WIDTH   = 8,
   parameter int P_NUM_PRED     = 2
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   output logic                                    ready_o,
   input  logic [P_NUM_PRED-1:0][31:1]             fw_pc_i,
   input  logic [P_NUM_PRED-1:0]                   fw_valid_i,
   output logic [P_NUM_PRED-1:0][31:1]             pred_pc_o,
   output logic [P_NUM_PRED-1:0][31:0]             pred_result_o,
   output logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   pred_conf_o,
   output logic [P_NUM_PRED-1:0]                   pred_valid_o,
   input  logic [P_NUM_PRED-1:0][31:1]             fb_pc_i,
   input  logic [P_NUM_PRED-1:0][31:0]             fb_actual_i,
   input  logic [P_NUM_PRED-1:0]                   fb_mispredict_i,
   input  logic [P_NUM_PRED-1:0][P_CONF_WIDTH:0]   fb_conf_i,
   input  logic [P_NUM_PRED-1:0]                   fb_valid_i
);

   localparam int P_INDEX_WIDTH = $clog2(P_STORAGE_SIZE);
   localparam int INIT_STEPS    = P_STORAGE_SIZE / P_NUM_PRED;
   localparam int CNT_W         = (INIT_STEPS > 1) ? $clog2(INIT_STEPS) : 1;
   localparam int SUM_W         = P_CONF_WIDTH + 2;
   localparam logic [P_CONF_WIDTH:0] CONF_SAT = {1'b1, {P_CONF_WIDTH{1'b0}}};

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t             state;
   logic [CNT_W-1:0]   init_cnt;

   logic [31:0]           last_mem [P_STORAGE_SIZE];
   logic [P_CONF_WIDTH:0] conf_mem [P_STORAGE_SIZE];
`ifdef VP_STRIDE_EN
   logic [31:0]           stride_mem [P_STORAGE_SIZE];
   logic [31:0]           wr_stride [P_NUM_PRED];
   logic [31:0]           prev_val;
`endif

   logic [P_NUM_PRED-1:0]    fb_live;
   logic [P_NUM_PRED-1:0]    wr_en;
   logic [P_INDEX_WIDTH-1:0] wr_idx  [P_NUM_PRED];
   logic [31:0]              wr_last [P_NUM_PRED];
   logic [P_CONF_WIDTH:0]    wr_conf [P_NUM_PRED];
   logic [P_INDEX_WIDTH-1:0] init_idx [P_NUM_PRED];
   logic [SUM_W-1:0]         grp_size;
   logic [SUM_W-1:0]         conf_sum;
   logic                     grp_misp;

   // A lane writes only if no higher lane carries the same PC; lower same-PC lanes fold into it.
   always_comb begin
      fb_live  = fb_valid_i & {P_NUM_PRED{state == ST_RUN}};
      wr_en    = '0;
      grp_size = '0;
      conf_sum = '0;
      grp_misp = 1'b0;
`ifdef VP_STRIDE_EN
      prev_val = '0;
`endif
      for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
         init_idx[i] = P_INDEX_WIDTH'(32'(init_cnt) * P_NUM_PRED + i);
         wr_idx[i]   = fb_pc_i[i][P_INDEX_WIDTH:1];
         wr_last[i]  = fb_actual_i[i];
         wr_en[i]    = fb_live[i];
         grp_size    = SUM_W'(1);
         grp_misp    = fb_mispredict_i[i];
`ifdef VP_STRIDE_EN
         prev_val    = last_mem[wr_idx[i]];
`endif
         for (int unsigned j = 0; j < P_NUM_PRED; j++) begin
            if (j != i && fb_live[j] && fb_pc_i[j] == fb_pc_i[i]) begin
               if (j > i) begin
                  wr_en[i] = 1'b0;
               end else begin
                  grp_size = grp_size + SUM_W'(1);
                  grp_misp = grp_misp | fb_mispredict_i[j];
`ifdef VP_STRIDE_EN
                  prev_val = fb_actual_i[j];
`endif
               end
            end
         end
         conf_sum = SUM_W'(fb_conf_i[i]) + grp_size;
         if (grp_misp)
            wr_conf[i] = '0;
         else if (conf_sum > SUM_W'(CONF_SAT))
            wr_conf[i] = CONF_SAT;
         else
            wr_conf[i] = conf_sum[P_CONF_WIDTH:0];
`ifdef VP_STRIDE_EN
         wr_stride[i] = fb_actual_i[i] - prev_val;
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state == ST_INIT) begin
            for (int unsigned j = 0; j < P_NUM_PRED; j++) begin
               last_mem[init_idx[j]] <= '0;
               conf_mem[init_idx[j]] <= '0;
`ifdef VP_STRIDE_EN
               stride_mem[init_idx[j]] <= '0;
`endif
            end
         end else begin
            for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
               if (wr_en[i]) begin
                  last_mem[wr_idx[i]] <= wr_last[i];
                  conf_mem[wr_idx[i]] <= wr_conf[i];
`ifdef VP_STRIDE_EN
                  stride_mem[wr_idx[i]] <= wr_stride[i];
`endif
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= ST_INIT;
         init_cnt      <= '0;
         ready_o       <= 1'b0;
         pred_valid_o  <= '0;
         pred_pc_o     <= '0;
         pred_result_o <= '0;
         pred_conf_o   <= '0;
      end else begin
         pred_pc_o    <= fw_pc_i;
         pred_valid_o <= fw_valid_i & {P_NUM_PRED{state == ST_RUN}};
         for (int unsigned i = 0; i < P_NUM_PRED; i++) begin
`ifdef VP_STRIDE_EN
            pred_result_o[i] <= last_mem[fw_pc_i[i][P_INDEX_WIDTH:1]]
                              + stride_mem[fw_pc_i[i][P_INDEX_WIDTH:1]];
`else
            pred_result_o[i] <= last_mem[fw_pc_i[i][P_INDEX_WIDTH:1]];
`endif
            pred_conf_o[i] <= conf_mem[fw_pc_i[i][P_INDEX_WIDTH:1]];
         end
         case (state)
            ST_INIT: begin
               if (init_cnt == CNT_W'(INIT_STEPS - 1)) begin
                  state   <= ST_RUN;
                  ready_o <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
